// File: rtl/aig_sweep_sig.sv
// Signature engine: sweeps every input vector onto a combinational (or pipelined)
// circuit under test and compacts its responses into a MISR signature.
module aig_sweep_sig #(
  parameter int               N_IN    = 9,
  parameter int               N_OUT   = 11,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021),
  parameter int               CAP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             sig_valid
);

  // Control protocol: start is a level sampled only while idle; busy stays high
  // from the cycle after an accepted start until the last capture; done is a
  // single-cycle pulse that coincides with sig_valid rising. abort wins over
  // completion and drops back to idle without a done pulse.

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam int              SR_W       = (CAP_LAT > 0) ? CAP_LAT : 1;
  localparam logic [N_IN:0]   LAST       = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0]   CNT_ONE    = (N_IN+1)'(1);
  localparam logic [2:0]      DRAIN_LAST = 3'((CAP_LAT > 0) ? CAP_LAT - 1 : 0);

  state_t           state;
  logic [N_IN:0]    cnt;
  logic [2:0]       drain_cnt;
  logic             mode_q;
  logic [SR_W-1:0]  vld_sr;
  logic [N_IN-1:0]  nxt_idx;
  logic [N_IN-1:0]  nxt_pat;
  logic [SIG_W-1:0] misr_next;
  logic             in_sweep;
  logic             drive_beat;
  logic             absorb;

  function automatic logic [N_IN-1:0] pattern(input logic m, input logic [N_IN-1:0] i);
    return m ? (i ^ (i >> 1)) : i;
  endfunction

  always_comb begin
    nxt_idx    = cnt[N_IN-1:0] + N_IN'(1);
    nxt_pat    = pattern(mode_q, nxt_idx);
    in_sweep   = (state == DRIVE) || (state == DRAIN);
    drive_beat = (state == DRIVE) && !abort;
    // With no capture latency the response is taken in the same cycle it is driven.
    absorb     = (CAP_LAT == 0) ? drive_beat : (in_sweep && !abort && vld_sr[SR_W-1]);
    misr_next  = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(f);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      mode_q    <= 1'b0;
      vld_sr    <= '0;
      x         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sig       <= '0;
      sig_valid <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld_sr <= SR_W'({vld_sr, drive_beat});
      if (absorb) sig <= misr_next;

      unique case (state)
        IDLE: begin
          x <= '0;
          if (start) begin
            state     <= DRIVE;
            cnt       <= '0;
            sig       <= '0;
            sig_valid <= 1'b0;
            mode_q    <= mode;
            vld_sr    <= '0;
            busy      <= 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            state     <= IDLE;
            x         <= '0;
            busy      <= 1'b0;
            sig_valid <= 1'b0;
          end else if (cnt == LAST) begin
            if (CAP_LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              sig_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
            x   <= nxt_pat;
          end
        end
        DRAIN: begin
          if (abort) begin
            state     <= IDLE;
            x         <= '0;
            busy      <= 1'b0;
            sig_valid <= 1'b0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sig_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          x     <= '0;
          if (abort) sig_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aig_sweep_sig.sv
// Bench for aig_sweep_sig: small loopback configs from a vector table, plus
// full-size sweeps against a signature model, abort and mid-sweep reset cases.
module tb_aig_sweep_sig;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [10:0] cut_fn(input logic [8:0] v);
    logic [10:0] a;
    a = {2'b00, v};
    return (a * 11'd37) ^ {v[3:0], v[8:2]} ^ 11'h2a5;
  endfunction

  function automatic int pat(input bit md, input int i);
    return md ? (i ^ (i >> 1)) : i;
  endfunction

  // Signature of a whole sweep, built straight from the pattern order and MISR rule.
  function automatic logic [15:0] model_sig(input bit md, input bit z);
    int s;
    int fv;
    s = 0;
    for (int i = 0; i < 512; i++) begin
      fv = z ? 0 : int'(cut_fn(9'(pat(md, i))));
      s  = ((s << 1) & 16'hffff) ^ (((s >> 15) & 1) != 0 ? 16'h1021 : 0) ^ fv;
    end
    return 16'(s);
  endfunction

  // ---- small loopback instances ----
  logic       s_start = 1'b0, s_mode = 1'b0, s_abort = 1'b0;
  logic [1:0] x_lp0, x_lp1, f_lp1;
  logic       busy_lp0, done_lp0, sv_lp0, busy_lp1, done_lp1, sv_lp1;
  logic [3:0] sig_lp0, sig_lp1;

  aig_sweep_sig #(.N_IN(2), .N_OUT(2), .SIG_W(4), .POLY(4'h3), .CAP_LAT(0)) u_lp0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .abort(s_abort),
    .x(x_lp0), .f(x_lp0), .busy(busy_lp0), .done(done_lp0), .sig(sig_lp0), .sig_valid(sv_lp0));

  aig_sweep_sig #(.N_IN(2), .N_OUT(2), .SIG_W(4), .POLY(4'h3), .CAP_LAT(1)) u_lp1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .abort(s_abort),
    .x(x_lp1), .f(f_lp1), .busy(busy_lp1), .done(done_lp1), .sig(sig_lp1), .sig_valid(sv_lp1));

  always_ff @(posedge clk) f_lp1 <= rst_n ? x_lp1 : 2'b00;

  // ---- full-size instances: combinational CUT and 3-stage pipelined CUT ----
  logic        g_start = 1'b0, g_mode = 1'b0, g_abort = 1'b0, tie0 = 1'b0;
  logic [8:0]  x_big, x_pip;
  logic [10:0] f_big, f_pip, p1, p2, p3;
  logic        busy_big, done_big, sv_big, busy_pip, done_pip, sv_pip;
  logic [15:0] sig_big, sig_pip;

  assign f_big = tie0 ? 11'd0 : cut_fn(x_big);
  assign f_pip = p3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      p1 <= tie0 ? 11'd0 : cut_fn(x_pip);
      p2 <= p1;
      p3 <= p2;
    end
  end

  aig_sweep_sig u_big (
    .clk(clk), .rst_n(rst_n), .start(g_start), .mode(g_mode), .abort(g_abort),
    .x(x_big), .f(f_big), .busy(busy_big), .done(done_big), .sig(sig_big), .sig_valid(sv_big));

  aig_sweep_sig #(.CAP_LAT(3)) u_pip (
    .clk(clk), .rst_n(rst_n), .start(g_start), .mode(g_mode), .abort(g_abort),
    .x(x_pip), .f(f_pip), .busy(busy_pip), .done(done_pip), .sig(sig_pip), .sig_valid(sv_pip));

  logic [8:0]  ox[2];
  logic        obusy[2], odone[2], osv[2];
  logic [15:0] osig[2];
  always_comb begin
    ox[0] = x_big;       ox[1] = x_pip;
    obusy[0] = busy_big; obusy[1] = busy_pip;
    odone[0] = done_big; odone[1] = done_pip;
    osv[0] = sv_big;     osv[1] = sv_pip;
    osig[0] = sig_big;   osig[1] = sig_pip;
  end

  // Full sweep on both big instances; abort_cyc = 0 means run to completion.
  task automatic run_sweep(input bit md, input bit hold, input int abort_cyc);
    int          done_cyc[2], done_n[2], x_err[2], busy_err[2], exp_end[2];
    int          lim, idle_from, xi;
    logic [15:0] exp_sig;
    exp_end[0] = 513;
    exp_end[1] = 516;
    exp_sig = model_sig(md, tie0);
    for (int k = 0; k < 2; k++) begin
      done_cyc[k] = 0; done_n[k] = 0; x_err[k] = 0; busy_err[k] = 0;
    end
    @(negedge clk);
    g_mode = md; g_start = 1'b1; g_abort = 1'b0;
    for (int c = 1; c <= 530; c++) begin
      @(negedge clk);
      g_start = hold && (c < 513);
      g_mode  = 1'($urandom_range(0, 1));
      g_abort = (c == abort_cyc);
      for (int k = 0; k < 2; k++) begin
        lim       = (abort_cyc > 0) ? abort_cyc : exp_end[k] - 1;
        idle_from = (abort_cyc > 0) ? abort_cyc + 1 : exp_end[k] + 1;
        if (odone[k]) begin done_n[k]++; done_cyc[k] = c; end
        if (obusy[k] !== (c <= lim)) busy_err[k]++;
        if (c <= lim) begin
          xi = (c - 1 > 511) ? 511 : c - 1;
          if (ox[k] !== 9'(pat(md, xi))) x_err[k]++;
        end else if (c >= idle_from) begin
          if (ox[k] !== 9'd0) x_err[k]++;
        end
      end
    end
    g_start = 1'b0; g_abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("x_seq[%0d]", k), x_err[k], 0);
      chk($sformatf("busy[%0d]", k), busy_err[k], 0);
      if (abort_cyc > 0) begin
        chk($sformatf("done_n_abort[%0d]", k), done_n[k], 0);
        chk($sformatf("sv_abort[%0d]", k), osv[k], 0);
      end else begin
        chk($sformatf("done_n[%0d]", k), done_n[k], 1);
        chk($sformatf("done_cyc[%0d]", k), done_cyc[k], exp_end[k]);
        chk($sformatf("sig[%0d]", k), osig[k], exp_sig);
        chk($sformatf("sig_valid[%0d]", k), osv[k], 1);
      end
    end
  endtask

  typedef struct {
    bit         lat1;
    bit         mode;
    logic [7:0] xs;
    logic [3:0] exp_sig;
    int         exp_done;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] xs_v;
    logic [1:0] xv;
    logic       bv, dv;
    int         done_cyc, done_n, x_err, busy_err;

    tbl[0] = '{1'b0, 1'b0, 8'b11_10_01_00, 4'h3, 5};
    tbl[1] = '{1'b0, 1'b1, 8'b10_11_01_00, 4'h0, 5};
    tbl[2] = '{1'b1, 1'b0, 8'b11_10_01_00, 4'h3, 6};
    tbl[3] = '{1'b1, 1'b1, 8'b10_11_01_00, 4'h0, 6};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", x_big, 0);
    chk("rst_busy", busy_big, 0);
    chk("rst_done", done_big, 0);
    chk("rst_sig", sig_big, 0);
    chk("rst_sv", sv_big, 0);
    chk("rst_sig_lp1", sig_lp1, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      xs_v = tbl[t].xs;
      done_cyc = 0; done_n = 0; x_err = 0; busy_err = 0;
      @(negedge clk);
      s_mode = tbl[t].mode; s_start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        s_start = 1'b0;
        s_mode  = ~s_mode;
        xv = tbl[t].lat1 ? x_lp1 : x_lp0;
        bv = tbl[t].lat1 ? busy_lp1 : busy_lp0;
        dv = tbl[t].lat1 ? done_lp1 : done_lp0;
        if (c <= 4 && xv !== xs_v[2*(c-1) +: 2]) x_err++;
        if (c > tbl[t].exp_done && xv !== 2'b00) x_err++;
        if (bv !== (c < tbl[t].exp_done)) busy_err++;
        if (dv) begin done_n++; done_cyc = c; end
      end
      chk($sformatf("t%0d_x", t), x_err, 0);
      chk($sformatf("t%0d_busy", t), busy_err, 0);
      chk($sformatf("t%0d_done_n", t), done_n, 1);
      chk($sformatf("t%0d_done_cyc", t), done_cyc, tbl[t].exp_done);
      chk($sformatf("t%0d_sig", t), tbl[t].lat1 ? sig_lp1 : sig_lp0, tbl[t].exp_sig);
      chk($sformatf("t%0d_sv", t), tbl[t].lat1 ? sv_lp1 : sv_lp0, 1);
    end

    // abort alone in idle leaves the finished result untouched
    @(negedge clk); s_abort = 1'b1;
    @(negedge clk); s_abort = 1'b0;
    chk("idle_abort_sv", sv_lp1, 1);
    chk("idle_abort_sig", sig_lp1, tbl[3].exp_sig);

    // start and abort together in idle: start wins, then abort cancels
    @(negedge clk); s_start = 1'b1; s_abort = 1'b1;
    @(negedge clk); s_start = 1'b0; s_abort = 1'b1;
    chk("sa_busy", busy_lp0, 1);
    chk("sa_sv", sv_lp0, 0);
    @(negedge clk); s_abort = 1'b0;
    chk("sa_abort_busy", busy_lp0, 0);
    chk("sa_abort_x", x_lp1, 0);
    chk("sa_abort_done", done_lp1, 0);
    chk("sa_abort_sv", sv_lp1, 0);
    repeat (4) @(negedge clk);

    tie0 = 1'b1;
    run_sweep(1'b0, 1'b0, 0);
    run_sweep(1'b0, 1'b1, 0);
    tie0 = 1'b0;
    run_sweep(1'b0, 1'b0, 0);
    run_sweep(1'b1, 1'b0, 0);
    run_sweep(1'($urandom_range(0, 1)), 1'b0, 0);
    run_sweep(1'b1, 1'b0, 100);
    run_sweep(1'b1, 1'b0, 0);

    // reset during a sweep, then a clean sweep must match the model
    @(negedge clk); g_mode = 1'b1; g_start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      g_start = 1'b0;
      if (c == 50) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("mrst_x", x_big, 0);
    chk("mrst_busy", busy_pip, 0);
    chk("mrst_done", done_big, 0);
    chk("mrst_sig", sig_big, 0);
    chk("mrst_sv", sv_pip, 0);
    rst_n = 1'b1;
    run_sweep(1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aig_sweep_sig.md
Name: aig_sweep_sig

Overview:
- Sequential signature engine for the combinational benchmark circuits in this dataset.
- On `start`, it sweeps all 2^N_IN input vectors onto a circuit under test (CUT). Vectors are applied in binary or Gray order.
- After a configurable capture latency, it compacts every CUT output vector into a MISR signature.
- Used to fingerprint BALANCED, original and optimised netlists, and to compare them cycle-for-cycle, in place of per-output combinational checks.

Parameters:
- N_IN, 9, CUT input count (1..16).
- N_OUT, 11, CUT output count; must satisfy N_OUT <= SIG_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits wide.
- CAP_LAT, 0, cycles from x change to valid f (0..7); covers registered or pipelined CUTs.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- mode  in  1  0 = binary order, 1 = Gray order (pattern i = i ^ (i>>1)); latched at start.
- abort  in  1  cancel the sweep in progress.
- x  out  N_IN  registered vector driven to the CUT.
- f  in  N_OUT  CUT outputs.
- busy  out  1  high in DRIVE and DRAIN.
- done  out  1  one-cycle pulse at sweep completion.
- sig  out  SIG_W  MISR signature.
- sig_valid  out  1  sig holds the result of a completed sweep.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; x=0, busy=0, done=0, sig=0, sig_valid=0; capture pipeline and counter cleared. Reset overrides all other inputs, including mid-sweep.
- States: IDLE, DRIVE, DRAIN, DONE.
- IDLE:
  - x=0.
  - If start=1 (call this cycle 0): go to DRIVE; cnt=0; sig=0; sig_valid=0; mode latched.
- DRIVE:
  - In cycle 1+i, x=pattern(i) for i=0..2^N_IN-1; cnt increments each cycle.
  - The cycle with cnt=2^N_IN-1 is last: go to DRAIN if CAP_LAT>0, else DONE.
  - cnt is N_IN+1 bits wide, so it never wraps before the terminal compare.
- Capture: a valid bit enters a CAP_LAT-deep shift register together with each driven pattern.
  - With CAP_LAT=0, f is absorbed at the edge that ends the same DRIVE cycle.
  - Otherwise f is absorbed when the delayed valid bit emerges.
- DRAIN: lasts exactly CAP_LAT cycles, absorbing the outstanding vectors; x holds the last pattern. Then go to DONE.
- MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(f). Exactly 2^N_IN absorptions per sweep.
- DONE: lasts one cycle.
  - done=1, sig_valid=1, busy=0; return to IDLE.
  - sig_valid stays high and sig stays frozen until the next accepted start or reset.
- Completion timing: done is asserted in cycle 2^N_IN + CAP_LAT + 1.
- start while busy or in DONE: ignored, no restart.
- mode changes mid-sweep: ignored.
- abort in DRIVE, DRAIN or DONE: next state IDLE.
  - sig_valid=0, done not pulsed, sig left at its partial value (not meaningful).
  - abort has priority over the terminal transition.
- abort in IDLE: no effect. When abort=1 and start=1 arrive together in IDLE, start wins.

Test Plan:
- Loopback, small config (N_IN=2, N_OUT=2, SIG_W=4, POLY=4'h3, CAP_LAT=0, f=x), mode=0 -> x sequence 0,1,2,3 in cycles 1..4; done in cycle 5; sig=4'h3; sig_valid=1.
- Same config, mode=1 -> x sequence 0,1,3,2; sig=4'h0; done in cycle 5.
- Same config, CAP_LAT=1, f = x registered once -> sig=4'h3; busy high in cycles 1..5; done in cycle 6.
- Default parameters, f tied to 0 -> x counts 0..511; done in cycle 513; sig=16'h0000. Repeat with start held high through the sweep -> only one sweep and one done pulse.
- abort in cycle 100 of a default sweep -> IDLE in cycle 101; x=0; no done; sig_valid=0. A fresh start then completes normally after 513 cycles.
- rst_n=0 in cycle 50, then start -> all outputs zero in the cycle after reset; the next sweep is bit-identical to an uninterrupted run.
